// File: rtl/mcpu_pkg.sv
// Multi-cycle MIPS control: shared encodings.
// State, opcode, funct, ALU and mux-select constants.
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXE    = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ_EXE  = 4'd8,
    S_J_EXE    = 4'd9,
    S_I_EXE    = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2,
    AOP_IMM   = 2'd3
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_OUT  = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_SL2 = 2'b11;

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Controller <-> datapath bundle.
// master = control unit, slave = datapath.
interface mcpu_ctrl_if;
  logic [31:0] Inst_in;
  logic        zero;
  logic        MIO_ready;
  logic        MemRead;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  PCSource;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALU_Control;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        CPU_MIO;
  logic [3:0]  state_out;

  modport master (
    input  Inst_in, zero, MIO_ready,
    output MemRead, MemWrite, IorD, IRWrite,
    output PCWrite, PCWriteCond, PCSource,
    output ALUSrcA, ALUSrcB, ALU_Control,
    output RegWrite, RegDst, MemtoReg,
    output CPU_MIO, state_out
  );

  modport slave (
    output Inst_in, zero, MIO_ready,
    input  MemRead, MemWrite, IorD, IRWrite,
    input  PCWrite, PCWriteCond, PCSource,
    input  ALUSrcA, ALUSrcB, ALU_Control,
    input  RegWrite, RegDst, MemtoReg,
    input  CPU_MIO, state_out
  );
endinterface

// File: rtl/mcpu_ctrl_alu_decoder.sv
// ALUOp + funct/opcode -> ALU_Control.
// Unknown funct or opcode falls back to add.
module alu_decoder
  import mcpu_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  input  logic [5:0] op,
  output logic [2:0] alu_ctrl
);

  // pick the ALU operation for the current ALUOp class
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (aluop)
      AOP_ADD: alu_ctrl = ALU_ADD;
      AOP_SUB: alu_ctrl = ALU_SUB;
      AOP_FUNCT: begin
        unique case (1'b1)
          funct == F_ADD: alu_ctrl = ALU_ADD;
          funct == F_SUB: alu_ctrl = ALU_SUB;
          funct == F_AND: alu_ctrl = ALU_AND;
          funct == F_OR:  alu_ctrl = ALU_OR;
          funct == F_XOR: alu_ctrl = ALU_XOR;
          funct == F_NOR: alu_ctrl = ALU_NOR;
          funct == F_SLT: alu_ctrl = ALU_SLT;
          funct == F_SRL: alu_ctrl = ALU_SRL;
          default:        alu_ctrl = ALU_ADD;
        endcase
      end
      AOP_IMM: begin
        unique case (1'b1)
          op == OP_ANDI: alu_ctrl = ALU_AND;
          op == OP_ORI:  alu_ctrl = ALU_OR;
          op == OP_SLTI: alu_ctrl = ALU_SLT;
          default:       alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control unit (Moore FSM).
// MCTRL_MIO_WAIT_EN: IF/MEM_RD/MEM_WR stall on MIO_ready.
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input logic        clk,
  input logic        rst,
  mcpu_ctrl_if.master bus
);

  state_t     state;
  state_t     state_nx;
  aluop_t     aluop;
  logic       alu_en;
  logic [2:0] dec_alu;
  logic [5:0] op;
  logic       mio_go;

  assign op = bus.Inst_in[31:26];

`ifdef MCTRL_MIO_WAIT_EN
  assign mio_go = bus.MIO_ready;
`else
  assign mio_go = 1'b1;
`endif

  alu_decoder u_alu_dec (
    .aluop    (aluop),
    .funct    (bus.Inst_in[5:0]),
    .op       (op),
    .alu_ctrl (dec_alu)
  );

  // state register, reset returns to fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IF;
    else     state <= state_nx;
  end

  // next state and Moore outputs
  always_comb begin
    state_nx        = S_IF;
    aluop           = AOP_ADD;
    alu_en          = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.PCSource    = PCS_ALU;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SRCB_RT;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    unique case (state)
      S_IF: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = mio_go;
        bus.PCWrite = mio_go;
        bus.ALUSrcB = SRCB_4;
        alu_en      = 1'b1;
        state_nx    = mio_go ? S_ID : S_IF;
      end
      S_ID: begin
        bus.ALUSrcB = SRCB_SL2;
        alu_en      = 1'b1;
        unique case (1'b1)
          op == OP_LW,
          op == OP_SW:    state_nx = S_MEM_ADDR;
          op == OP_RTYPE: state_nx = S_R_EXE;
          op == OP_BEQ:   state_nx = S_BEQ_EXE;
          op == OP_J:     state_nx = S_J_EXE;
          op == OP_ADDI,
          op == OP_ANDI,
          op == OP_ORI,
          op == OP_SLTI:  state_nx = S_I_EXE;
          default:        state_nx = S_IF;
        endcase
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        alu_en      = 1'b1;
        state_nx    = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        state_nx    = mio_go ? S_LW_WB : S_MEM_RD;
      end
      S_LW_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        state_nx     = S_IF;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        state_nx     = mio_go ? S_IF : S_MEM_WR;
      end
      S_R_EXE: begin
        bus.ALUSrcA = 1'b1;
        aluop       = AOP_FUNCT;
        alu_en      = 1'b1;
        state_nx    = S_R_WB;
      end
      S_R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_nx     = S_IF;
      end
      S_BEQ_EXE: begin
        bus.ALUSrcA     = 1'b1;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCS_OUT;
        aluop           = AOP_SUB;
        alu_en          = 1'b1;
        state_nx        = S_IF;
      end
      S_J_EXE: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_JUMP;
        state_nx     = S_IF;
      end
      S_I_EXE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
        aluop       = AOP_IMM;
        alu_en      = 1'b1;
        state_nx    = S_I_WB;
      end
      S_I_WB: begin
        bus.RegWrite = 1'b1;
        state_nx     = S_IF;
      end
      default: state_nx = S_IF;
    endcase
    if (rst) begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.MemWrite    = 1'b0;
    end
  end

  // derived outputs
  assign bus.ALU_Control = alu_en ? dec_alu : 3'b000;
  assign bus.CPU_MIO     = bus.MemRead | bus.MemWrite;
  assign bus.state_out   = state;

endmodule

// File: doc/mcpu_ctrl.md
# mcpu_ctrl

Multi-cycle MIPS control unit that sits directly upstream of the datapath and drives its control inputs each cycle. It decodes the instruction held in the datapath's instruction register and sequences fetch/decode/execute/memory/write-back as a Moore state machine. It replaces the single-cycle combinational controller so that one ALU and one memory port can be shared across cycles.

## Interface
Parameters:
- none; state and opcode encodings come from `mcpu_pkg`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `Inst_in`  in  32  instruction register contents from datapath; bits [31:26] opcode, [5:0] funct
- `zero`  in  1  ALU zero flag from datapath
- `MIO_ready`  in  1  memory/IO ready; used only when `MCTRL_MIO_WAIT_EN` is defined
- `MemRead`, `MemWrite`, `IorD`, `IRWrite`  out  1 each  memory and instruction-register control
- `PCWrite`, `PCWriteCond`  out  1 each  PC enable; the datapath loads PC when `PCWrite | (PCWriteCond & zero)`
- `PCSource`  out  2  PC mux select: 00 = ALU result, 01 = ALUOut register, 10 = jump target
- `ALUSrcA`  out  1  ALU A mux select: 0 = PC, 1 = rs
- `ALUSrcB`  out  2  ALU B mux select: 00 = rt, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- `ALU_Control`  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt, 100 nor, 011 xor, 101 srl
- `RegWrite`, `RegDst`, `MemtoReg`  out  1 each  register-file write controls
- `CPU_MIO`  out  1  high whenever a memory access is requested
- `state_out`  out  4  current state, for debug display

## Operation
- States (4-bit): IF=0, ID=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXE=6, R_WB=7, BEQ_EXE=8, J_EXE=9, I_EXE=10, I_WB=11.
- IF: `MemRead`=1, `IRWrite`=1, `PCWrite`=1, `ALUSrcA`=0, `ALUSrcB`=01, add, `PCSource`=00. Always goes to ID.
- ID: `ALUSrcA`=0, `ALUSrcB`=11, add (branch target into ALUOut). Next state by opcode:
  - lw 100011 or sw 101011 → MEM_ADDR
  - R-type 000000 → R_EXE
  - beq 000100 → BEQ_EXE
  - j 000010 → J_EXE
  - addi 001000, andi 001100, ori 001101, slti 001010 → I_EXE
  - any other opcode → IF (executes as a nop)
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, add. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: `MemRead`=1, `IorD`=1. Next state LW_WB.
- LW_WB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Next state IF.
- MEM_WR: `MemWrite`=1, `IorD`=1. Next state IF.
- R_EXE: `ALUSrcA`=1, `ALUSrcB`=00, ALU op from funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 000010 srl
  - unknown funct → add
  - Next state R_WB.
- R_WB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Next state IF.
- BEQ_EXE: `ALUSrcA`=1, `ALUSrcB`=00, sub, `PCWriteCond`=1, `PCSource`=01. Next state IF.
- J_EXE: `PCWrite`=1, `PCSource`=10. Next state IF.
- I_EXE: `ALUSrcA`=1, `ALUSrcB`=10, ALU op: addi add, andi and, ori or, slti slt. Next state I_WB.
- I_WB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Next state IF.
- Outputs not listed for a state are 0.
- `CPU_MIO` = `MemRead | MemWrite`.

## Timing
- Outputs are a pure function of state and the `Inst_in` opcode/funct (Moore-style). `zero` is never used inside the FSM.
- Cycle counts without waits: lw 5, sw 4, R-type 4, I-type 4, beq 3, j 3.
- Reset:
  - `rst` high clears state to IF immediately (asynchronous), including mid-instruction.
  - While `rst`=1, `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite` and `MemWrite` are forced to 0. Other outputs take their IF values.
  - `state_out`=0 during reset.
  - After `rst` falls, the first rising edge completes IF.
- `Inst_in` must be stable from ID through the end of the instruction. IR is only written in IF.

## Configuration
- `MCTRL_MIO_WAIT_EN` defined:
  - IF, MEM_RD and MEM_WR hold their state until `MIO_ready`=1.
  - In IF, `PCWrite` and `IRWrite` are asserted only in the cycle where `MIO_ready`=1.
  - `MemRead`/`MemWrite` stay high for the whole wait.
- Not defined: `MIO_ready` is ignored and every state lasts exactly one cycle.

## Structure
- `mcpu_pkg`: state encodings, opcode and funct constants, ALU_Control codes, `PCSource`/`ALUSrcB` encodings.
- Sub-module `alu_decoder`: combinational; maps a 2-bit ALUOp (add / sub / funct / imm-op) plus funct and opcode to `ALU_Control`.
- FSM next-state and output decode live in `mcpu_ctrl`.

## Test plan
- Reset mid-instruction: assert `rst` in MEM_RD → `state_out`=0 at once and all write enables 0. After release, IF→ID on the next two edges.
- add $3,$1,$2 (0x00221820) → states 0,1,6,7,0. In R_EXE `ALU_Control`=010; in R_WB `RegWrite`=1, `RegDst`=1.
- lw $2,4($1) (0x8C220004) → states 0,1,2,3,4,0. `IorD`=1 and `MemRead`=1 in state 3; `MemtoReg`=1 and `RegWrite`=1 in state 4.
- sw $2,8($1) (0xAC220008) → states 0,1,2,5,0. `MemWrite`=1 only in state 5.
- beq (0x10220003) → states 0,1,8,0 with `PCWriteCond`=1, `PCSource`=01, `ALU_Control`=110. j (0x08000100) → states 0,1,9,0 with `PCWrite`=1, `PCSource`=10.
- With `MCTRL_MIO_WAIT_EN`: `MIO_ready`=0 for 3 cycles in IF → state stays 0 and `PCWrite`=0. Once `MIO_ready`=1, `PCWrite`=1 and `IRWrite`=1 for one cycle, then state 1. Opcode 111111 → ID→IF with no writes.
